cache_loader: RTL and testbench

//  Write-side producer for the 7-channel line cache. Accepts a valid/ready byte stream

---
 rtl/cache_loader_if.sv | 46 ++++
 rtl/cache_loader.sv | 193 +++++++++++++++++++
 tb/tb_cache_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_loader_if.sv
// cache_loader_if
//   Bundles the load-job control, the incoming byte stream and the cache write
//   port of cache_loader.
//   Modports:
//     slave  - the loader itself (consumes the stream, drives the cache port)
//     master - the job issuer / stream source / cache model
//   Signals:
//     start_i, row_length_i, num_channels_i   job request (LEN / NCH)
//     data_i, data_valid_i, data_ready_o      byte stream
//     wr_en_o, channel_wr_sel_o, address_wr_o, cache_data_o   cache write port
//     busy_o, done_o                          job status
//     state_dbg_o                             current FSM state, for observation
//   Stream handshake: a word transfers on a rising edge where data_valid_i and
//   data_ready_o are both high; the source holds data_i stable while valid is
//   high and not yet accepted, and ready never depends on valid.
interface cache_loader_if #(
  parameter int BIT_WIDTH               = 8,
  parameter int CACHE_CHANNEL_BIT_WIDTH = 3,
  parameter int CACHE_ADDRESS_BIT_WIDTH = 5
);
  logic                               start_i;
  logic [5:0]                         row_length_i;
  logic [2:0]                         num_channels_i;
  logic [BIT_WIDTH-1:0]               data_i;
  logic                               data_valid_i;
  logic                               data_ready_o;
  logic                               wr_en_o;
  logic [CACHE_CHANNEL_BIT_WIDTH-1:0] channel_wr_sel_o;
  logic [CACHE_ADDRESS_BIT_WIDTH-1:0] address_wr_o;
  logic [BIT_WIDTH-1:0]               cache_data_o;
  logic                               busy_o;
  logic                               done_o;
  logic [1:0]                         state_dbg_o;

  modport slave (
    input  start_i, row_length_i, num_channels_i, data_i, data_valid_i,
    output data_ready_o, wr_en_o, channel_wr_sel_o, address_wr_o, cache_data_o,
           busy_o, done_o, state_dbg_o
  );

  modport master (
    output start_i, row_length_i, num_channels_i, data_i, data_valid_i,
    input  data_ready_o, wr_en_o, channel_wr_sel_o, address_wr_o, cache_data_o,
           busy_o, done_o, state_dbg_o
  );
endinterface

// File: rtl/cache_loader.sv
// cache_loader
//   Write-side producer for the 7-channel line cache. Takes a valid/ready byte
//   stream and writes it channel-major (ch0 a0..LEN-1, ch1 a0..LEN-1, ...),
//   then pulses done_o so reads may begin.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous reset, active-high (abandons any job, no done_o)
//     bus  - cache_loader_if.slave: job request, stream, cache write port,
//            busy/done status and FSM state debug output
//   Optional feature: define CACHE_LOADER_ZERO_FILL_EN to pad each channel
//   with 0x00 from address LEN up to 31 before moving on.
//   Write timing: every cache write is registered, so it appears exactly one
//   cycle after the handshake (or fill step) that produced it.
module cache_loader #(
  parameter int BIT_WIDTH               = 8,
  parameter int CHANNEL_DEPTH           = 32,
  parameter int CACHE_CHANNELS          = 7,
  parameter int CACHE_CHANNEL_BIT_WIDTH = 3,
  parameter int CACHE_ADDRESS_BIT_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  cache_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_FILL = 2'd3
  } state_t;

  localparam logic [5:0] LP_DEPTH    = 6'(CHANNEL_DEPTH);
  localparam logic [2:0] LP_CHANNELS = 3'(CACHE_CHANNELS);

  state_t r_state;
  state_t w_next_state;

  logic [5:0]                         r_len;
  logic [2:0]                         r_nch;
  logic [CACHE_CHANNEL_BIT_WIDTH-1:0] r_chan;
  logic [CACHE_ADDRESS_BIT_WIDTH-1:0] r_addr;

  logic                               r_wr_en;
  logic [CACHE_CHANNEL_BIT_WIDTH-1:0] r_wr_chan;
  logic [CACHE_ADDRESS_BIT_WIDTH-1:0] r_wr_addr;
  logic [BIT_WIDTH-1:0]               r_wr_data;

  logic       w_ready;
  logic       w_busy;
  logic       w_done;
  logic       w_hs;
  logic       w_last_addr;
  logic       w_last_chan;
  logic [5:0] w_len_clamped;
  logic [2:0] w_nch_clamped;
`ifdef CACHE_LOADER_ZERO_FILL_EN
  logic       w_needs_fill;
  logic       w_fill_end;
`endif

  // Out-of-range job sizes fall back to the full cache geometry.
  assign w_len_clamped = ((bus.row_length_i == 6'd0) || (bus.row_length_i > LP_DEPTH))
                         ? LP_DEPTH : bus.row_length_i;
  assign w_nch_clamped = ((bus.num_channels_i == 3'd0) || (bus.num_channels_i > LP_CHANNELS))
                         ? LP_CHANNELS : bus.num_channels_i;

  assign w_hs        = bus.data_valid_i & w_ready;
  assign w_last_addr = ({1'b0, r_addr} == (r_len - 6'd1));
  assign w_last_chan = (r_chan == (r_nch - 3'd1));
`ifdef CACHE_LOADER_ZERO_FILL_EN
  assign w_needs_fill = (r_len != LP_DEPTH);
  assign w_fill_end   = (r_addr == 5'(CHANNEL_DEPTH - 1));
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and status outputs
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start_i) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        // Leaving LOAD drops ready in the same cycle, so the word that
        // completes the job is the last one accepted.
        if (w_hs && w_last_addr) begin
`ifdef CACHE_LOADER_ZERO_FILL_EN
          if (w_needs_fill)     w_next_state = S_FILL;
          else if (w_last_chan) w_next_state = S_DONE;
`else
          if (w_last_chan)      w_next_state = S_DONE;
`endif
        end
      end
`ifdef CACHE_LOADER_ZERO_FILL_EN
      S_FILL: begin
        if (w_fill_end) w_next_state = w_last_chan ? S_DONE : S_LOAD;
      end
`endif
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Job counters and registered cache write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_nch     <= '0;
      r_chan    <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_chan <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_len  <= w_len_clamped;
            r_nch  <= w_nch_clamped;
            r_chan <= '0;
            r_addr <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_wr_en   <= 1'b1;
            r_wr_chan <= r_chan;
            r_wr_addr <= r_addr;
            r_wr_data <= bus.data_i;
            if (w_last_addr) begin
`ifdef CACHE_LOADER_ZERO_FILL_EN
              if (w_needs_fill) begin
                // Stay on this channel; padding starts right after the data.
                r_addr <= r_len[4:0];
              end else begin
                r_addr <= '0;
                r_chan <= r_chan + 1'b1;
              end
`else
              r_addr <= '0;
              r_chan <= r_chan + 1'b1;
`endif
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
`ifdef CACHE_LOADER_ZERO_FILL_EN
        S_FILL: begin
          r_wr_en   <= 1'b1;
          r_wr_chan <= r_chan;
          r_wr_addr <= r_addr;
          r_wr_data <= '0;
          if (w_fill_end) begin
            r_addr <= '0;
            r_chan <= r_chan + 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.data_ready_o     = w_ready;
  assign bus.busy_o           = w_busy;
  assign bus.done_o           = w_done;
  assign bus.wr_en_o          = r_wr_en;
  assign bus.channel_wr_sel_o = r_wr_chan;
  assign bus.address_wr_o     = r_wr_addr;
  assign bus.cache_data_o     = r_wr_data;
  assign bus.state_dbg_o      = r_state;

endmodule

// File: tb/tb_cache_loader.sv
module tb_cache_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_loader_if bus ();

  cache_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  // Entry format: {channel[2:0], address[4:0], data[7:0]}
  logic [15:0] exp_q[$];
  logic [15:0] cap_q[$];
  int          done_cnt = 0;
  int          lat_err  = 0;
  bit          hs_pend  = 0;

  // Sampled on the falling edge: records writes, done pulses and checks that
  // each write lands exactly one cycle after its handshake.
  always @(negedge clk) begin
    if (rst) begin
      hs_pend = 0;
    end else begin
      if (bus.wr_en_o === 1'b1)
        cap_q.push_back({bus.channel_wr_sel_o, bus.address_wr_o, bus.cache_data_o});
`ifdef CACHE_LOADER_ZERO_FILL_EN
      if (hs_pend && bus.wr_en_o !== 1'b1) lat_err++;
      if (!hs_pend && bus.wr_en_o === 1'b1 && bus.cache_data_o !== 8'h00) lat_err++;
`else
      if (bus.wr_en_o !== hs_pend) lat_err++;
`endif
      if (bus.done_o === 1'b1) done_cnt++;
      hs_pend = (bus.data_valid_i === 1'b1) && (bus.data_ready_o === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [5:0] len, input logic [2:0] nch);
    bus.start_i        = 1'b1;
    bus.row_length_i   = len;
    bus.num_channels_i = nch;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [7:0] d, output bit ok);
    bit hs;
    ok = 0;
    bus.data_valid_i = 1'b1;
    bus.data_i       = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      hs = (bus.data_ready_o === 1'b1);
      @(posedge clk); #1;
      if (hs) begin
        ok = 1;
        break;
      end
    end
    bus.data_valid_i = 1'b0;
  endtask

  task automatic run_job(input logic [5:0] len_in, input logic [2:0] nch_in,
                         input logic [7:0] d0, input bit toggle, input bit mid_start,
                         input string name);
    int eff_len, eff_nch, total, waited, ncmp;
    bit ok;
    eff_len = (len_in == 0 || len_in > 32) ? 32 : int'(len_in);
    eff_nch = (nch_in == 0) ? 7 : int'(nch_in);
    total   = eff_len * eff_nch;
    exp_q.delete();
    for (int c = 0; c < eff_nch; c++) begin
      for (int a = 0; a < eff_len; a++)
        exp_q.push_back({3'(c), 5'(a), d0 + 8'(c * eff_len + a)});
`ifdef CACHE_LOADER_ZERO_FILL_EN
      for (int a = eff_len; a < 32; a++)
        exp_q.push_back({3'(c), 5'(a), 8'h00});
`endif
    end

    @(posedge clk); #1;
    cap_q.delete(); done_cnt = 0; lat_err = 0;
    pulse_start(len_in, nch_in);
    n_tests++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, bus.busy_o);
    end

    for (int w = 0; w < total; w++) begin
      send_word(d0 + 8'(w), ok);
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL %s accept_timeout: word %0d not accepted, expected accepted", name, w);
        break;
      end
      if (mid_start && w == 2) pulse_start(6'd1, 3'd1);
      if (toggle) begin
        @(posedge clk); #1;
      end
    end

    // Offer one more word straight away; it must not be taken.
    bus.data_valid_i = 1'b1;
    bus.data_i       = 8'hEE;
    waited = 0;
    while (done_cnt == 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (3) @(posedge clk);
    #1;
    bus.data_valid_i = 1'b0;

    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end
    n_tests++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", name, cap_q.size(), exp_q.size());
    end
    ncmp = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < ncmp; i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got ch%0d a%0d d%02h expected ch%0d a%0d d%02h",
                 name, i, cap_q[i][15:13], cap_q[i][12:8], cap_q[i][7:0],
                 exp_q[i][15:13], exp_q[i][12:8], exp_q[i][7:0]);
      end
    end
    n_tests++;
    if (lat_err != 0) begin
      n_fail++;
      $display("FAIL %s write_latency: got %0d timing errors expected 0", name, lat_err);
    end
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.data_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_done: got busy=%b ready=%b expected 0/0",
               name, bus.busy_o, bus.data_ready_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0; bus.row_length_i = '0; bus.num_channels_i = '0;
    bus.data_i = '0; bus.data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.data_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.data_ready_o); end
    n_tests++;
    if (bus.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en_o); end
    n_tests++;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    n_tests++;
    if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    n_tests++;
    if ({bus.channel_wr_sel_o, bus.address_wr_o, bus.cache_data_o} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_write_port: got ch%0d a%0d d%02h expected all 0",
               bus.channel_wr_sel_o, bus.address_wr_o, bus.cache_data_o);
    end
    n_tests++;
    if (bus.state_dbg_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg_o); end
  endtask

  task automatic test_basic();
    run_job(6'd4, 3'd2, 8'h10, 0, 0, "basic");
  endtask

  task automatic test_valid_toggle();
    run_job(6'd4, 3'd2, 8'h10, 1, 0, "toggle");
  endtask

  task automatic test_clamp();
    run_job(6'd0, 3'd0, 8'h00, 0, 0, "clamp_224");
    n_tests++;
    if (cap_q.size() == 0 || cap_q[cap_q.size()-1] !== {3'd6, 5'd31, 8'hDF}) begin
      n_fail++;
      $display("FAIL clamp_last_write: got %0d entries, last %04h expected ch6 a31 dDF",
               cap_q.size(), (cap_q.size() == 0) ? 16'h0 : cap_q[cap_q.size()-1]);
    end
    run_job(6'd40, 3'd1, 8'h80, 0, 0, "clamp_len40");
  endtask

  task automatic test_start_ignored();
    run_job(6'd4, 3'd2, 8'h20, 0, 1, "start_mid_job");
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int exp_cap;
    @(posedge clk); #1;
    cap_q.delete(); done_cnt = 0; lat_err = 0;
    pulse_start(6'd4, 3'd2);
    for (int w = 0; w < 5; w++) send_word(8'h50 + 8'(w), ok);
`ifdef CACHE_LOADER_ZERO_FILL_EN
    exp_cap = 32;
`else
    exp_cap = 4;
`endif
    // Fifth write (ch1/a0) is on the port right now.
    n_tests++;
    if (bus.wr_en_o !== 1'b1 || bus.channel_wr_sel_o !== 3'd1) begin
      n_fail++;
      $display("FAIL rstmid_pre_write: got wr_en=%b ch%0d expected 1 ch1", bus.wr_en_o, bus.channel_wr_sel_o);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.wr_en_o, bus.data_ready_o, bus.busy_o, bus.done_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: got wr_en/ready/busy/done=%b%b%b%b expected 0000",
               bus.wr_en_o, bus.data_ready_o, bus.busy_o, bus.done_o);
    end
    n_tests++;
    if ({bus.channel_wr_sel_o, bus.address_wr_o, bus.cache_data_o} !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid_write_port: got ch%0d a%0d d%02h expected all 0",
               bus.channel_wr_sel_o, bus.address_wr_o, bus.cache_data_o);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    n_tests++;
    if (cap_q.size() != exp_cap) begin
      n_fail++;
      $display("FAIL rstmid_writes: got %0d expected %0d", cap_q.size(), exp_cap);
    end
    run_job(6'd2, 3'd1, 8'h60, 0, 0, "restart_after_rst");
  endtask

`ifdef CACHE_LOADER_ZERO_FILL_EN
  task automatic test_zero_fill();
    run_job(6'd30, 3'd1, 8'h30, 0, 0, "zero_fill_30x1");
    run_job(6'd31, 3'd2, 8'h40, 1, 0, "zero_fill_31x2");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_valid_toggle();
    test_clamp();
    test_start_ignored();
    test_reset_mid_job();
`ifdef CACHE_LOADER_ZERO_FILL_EN
    test_zero_fill();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
